// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between the MEM stage and a single-outstanding data bus.
// Boundary-crossing accesses are split into two aligned beats and the read data is merged.
module lsu_mem_sequencer #(
    parameter int XLEN               = 32,
    parameter int ADDR_W             = 32,
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [2:0]        i_req_type,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_be,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata,
    input  logic              i_mem_err,
    output logic              o_rsp_valid,
    output logic              o_rsp_err,
    output logic [XLEN-1:0]   o_rsp_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, BEAT1, WAIT1, BEAT2, WAIT2, RESP} state_t;

    state_t            state, state_n;
    logic              write_q, uns_q, cross_q, err_q;
    logic [3:0]        size_q;
    logic [OW-1:0]     off_q;
    logic [ADDR_W-1:0] base_q;
    logic [XLEN-1:0]   wdata_q, d1_q, d2_q;

    logic [3:0]        dec_size;
    logic              dec_bad, dec_cross;
    logic [OW-1:0]     dec_off;

    always_comb begin
        dec_size = 4'd0;
        dec_bad  = 1'b0;
        dec_off  = i_req_addr[OW-1:0];
        case (i_req_type)
            3'b000, 3'b100: dec_size = 4'd1;
            3'b001, 3'b101: dec_size = 4'd2;
            3'b010:         dec_size = 4'd4;
            3'b011: begin dec_size = 4'd8; dec_bad = (XLEN == 32); end
            3'b110: begin dec_size = 4'd4; dec_bad = (XLEN == 32); end
            default:        dec_bad  = 1'b1;
        endcase
        if (i_req_write && i_req_type[2]) dec_bad = 1'b1;
        dec_cross = (5'(dec_off) + 5'(dec_size)) > 5'(NB);
        if (dec_cross && !SUPPORT_MISALIGNED) dec_bad = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && i_req_valid) begin
                write_q <= i_req_write;
                uns_q   <= i_req_type[2];
                cross_q <= dec_cross;
                err_q   <= dec_bad;
                size_q  <= dec_size;
                off_q   <= dec_off;
                base_q  <= {i_req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                wdata_q <= i_req_wdata;
                d1_q    <= '0;
                d2_q    <= '0;
            end
            if (state == WAIT1 && i_mem_rvalid) begin
                d1_q  <= i_mem_rdata;
                err_q <= i_mem_err;
            end
            if (state == WAIT2 && i_mem_rvalid) begin
                d2_q  <= i_mem_rdata;
                err_q <= i_mem_err;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (i_req_valid) state_n = dec_bad ? RESP : BEAT1;
            BEAT1: if (i_mem_gnt) state_n = WAIT1;
            WAIT1: if (i_mem_rvalid) state_n = (i_mem_err || !cross_q) ? RESP : BEAT2;
            BEAT2: if (i_mem_gnt) state_n = WAIT2;
            WAIT2: if (i_mem_rvalid) state_n = RESP;
            RESP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    logic [2*XLEN-1:0] w2, r2;
    logic [2*NB-1:0]   be_mask, be2;
    logic [XLEN-1:0]   lo, ext;
    logic              sbit, beat2;
    int                msb;

    // Store lanes and load merge both work on a double-width window shifted by the byte offset.
    always_comb begin
        w2 = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
        for (int i = 0; i < 2*NB; i++) be_mask[i] = (i < int'(size_q));
        be2 = be_mask << off_q;
        r2  = {d2_q, d1_q} >> {off_q, 3'b000};
        lo  = r2[XLEN-1:0];
        msb = 8 * int'(size_q) - 1;
        sbit = 1'b0;
        for (int i = 0; i < XLEN; i++) if (i == msb) sbit = lo[i];
        for (int i = 0; i < XLEN; i++) ext[i] = (i <= msb) ? lo[i] : (sbit & ~uns_q);
    end

    always_comb begin
        beat2       = (state == BEAT2);
        o_req_ready = (state == IDLE);
        o_mem_req   = (state == BEAT1) || beat2;
        o_mem_we    = o_mem_req && write_q;
        o_mem_addr  = o_mem_req ? (base_q + (beat2 ? ADDR_W'(NB) : '0)) : '0;
        o_mem_wdata = o_mem_we ? (beat2 ? w2[2*XLEN-1:XLEN] : w2[XLEN-1:0]) : '0;
        o_mem_be    = o_mem_we ? (beat2 ? be2[2*NB-1:NB] : be2[NB-1:0]) : '0;
        o_rsp_valid = (state == RESP);
        o_rsp_err   = o_rsp_valid && err_q;
        o_rsp_rdata = (o_rsp_valid && !err_q && !write_q) ? ext : '0;
    end
endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Scoreboard bench for lsu_mem_sequencer: three configurations share one stimulus path,
// expected beats and responses are queued before each request and popped as the DUT emits them.
module tb_lsu_mem_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_write, gnt, rvalid, merr;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, rdata;
    int          dsel;

    logic        a_rdy, a_mreq, a_we, a_rv, a_re;
    logic [31:0] a_addr, a_wd, a_rd;
    logic [3:0]  a_be;
    logic        b_rdy, b_mreq, b_we, b_rv, b_re;
    logic [31:0] b_addr, b_wd, b_rd;
    logic [3:0]  b_be;
    logic        c_rdy, c_mreq, c_we, c_rv, c_re;
    logic [31:0] c_addr;
    logic [63:0] c_wd, c_rd;
    logic [7:0]  c_be;

    lsu_mem_sequencer #(.XLEN(32), .ADDR_W(32), .SUPPORT_MISALIGNED(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && dsel == 0), .o_req_ready(a_rdy),
        .i_req_write(req_write), .i_req_type(req_type), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata[31:0]), .o_mem_req(a_mreq), .i_mem_gnt(gnt), .o_mem_we(a_we),
        .o_mem_addr(a_addr), .o_mem_wdata(a_wd), .o_mem_be(a_be), .i_mem_rvalid(rvalid),
        .i_mem_rdata(rdata[31:0]), .i_mem_err(merr), .o_rsp_valid(a_rv), .o_rsp_err(a_re),
        .o_rsp_rdata(a_rd));

    lsu_mem_sequencer #(.XLEN(32), .ADDR_W(32), .SUPPORT_MISALIGNED(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && dsel == 1), .o_req_ready(b_rdy),
        .i_req_write(req_write), .i_req_type(req_type), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata[31:0]), .o_mem_req(b_mreq), .i_mem_gnt(gnt), .o_mem_we(b_we),
        .o_mem_addr(b_addr), .o_mem_wdata(b_wd), .o_mem_be(b_be), .i_mem_rvalid(rvalid),
        .i_mem_rdata(rdata[31:0]), .i_mem_err(merr), .o_rsp_valid(b_rv), .o_rsp_err(b_re),
        .o_rsp_rdata(b_rd));

    lsu_mem_sequencer #(.XLEN(64), .ADDR_W(32), .SUPPORT_MISALIGNED(1'b1)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && dsel == 2), .o_req_ready(c_rdy),
        .i_req_write(req_write), .i_req_type(req_type), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_mem_req(c_mreq), .i_mem_gnt(gnt), .o_mem_we(c_we),
        .o_mem_addr(c_addr), .o_mem_wdata(c_wd), .o_mem_be(c_be), .i_mem_rvalid(rvalid),
        .i_mem_rdata(rdata), .i_mem_err(merr), .o_rsp_valid(c_rv), .o_rsp_err(c_re),
        .o_rsp_rdata(c_rd));

    logic        req_ready, m_req, m_we, rsp_valid, rsp_err;
    logic [31:0] m_addr;
    logic [63:0] m_wdata, rsp_rdata;
    logic [7:0]  m_be;

    always_comb begin
        case (dsel)
            0: begin
                req_ready = a_rdy; m_req = a_mreq; m_we = a_we; m_addr = a_addr;
                m_wdata = {32'b0, a_wd}; m_be = {4'b0, a_be};
                rsp_valid = a_rv; rsp_err = a_re; rsp_rdata = {32'b0, a_rd};
            end
            1: begin
                req_ready = b_rdy; m_req = b_mreq; m_we = b_we; m_addr = b_addr;
                m_wdata = {32'b0, b_wd}; m_be = {4'b0, b_be};
                rsp_valid = b_rv; rsp_err = b_re; rsp_rdata = {32'b0, b_rd};
            end
            default: begin
                req_ready = c_rdy; m_req = c_mreq; m_we = c_we; m_addr = c_addr;
                m_wdata = c_wd; m_be = c_be;
                rsp_valid = c_rv; rsp_err = c_re; rsp_rdata = c_rd;
            end
        endcase
    end

    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic        we;
    } beat_t;
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    int    checks = 0;
    int    fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_beat(input logic [31:0] a, input logic [63:0] wd, input logic [7:0] be,
                            input logic we);
        beat_t b;
        b.addr = a; b.wdata = wd; b.be = be; b.we = we;
        beat_q.push_back(b);
    endtask

    task automatic exp_rsp(input logic [63:0] rd, input logic err, input int lat);
        rsp_t r;
        r.rdata = rd; r.err = err; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    // Issue one request and act as the bus: first grant after gnt_lat waiting cycles,
    // later grants immediate, rvalid one cycle after each grant.
    task automatic run(input string tag, input int sel, input logic wr, input logic [2:0] ty,
                       input logic [31:0] addr, input logic [63:0] wd, input int gnt_lat,
                       input logic [63:0] rd1, input logic [63:0] rd2, input logic err1);
        beat_t b;
        rsp_t  r;
        bit    done = 1'b0, pend = 1'b0;
        int    bidx = 0, waited = 0;
        dsel = sel;
        @(negedge clk);
        chk({tag, ".ready"}, req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_type = ty; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; rdata = '0;
            if (pend) begin
                rvalid = 1'b1;
                rdata  = (bidx == 1) ? rd1 : rd2;
                merr   = (bidx == 1) && err1;
                pend   = 1'b0;
            end
            if (m_req) begin
                if (beat_q.size() == 0) chk({tag, ".unexp_beat"}, m_req, 0);
                else begin
                    b = beat_q[0];
                    chk({tag, ".addr"}, m_addr, b.addr);
                    chk({tag, ".wdata"}, m_wdata, b.wdata);
                    chk({tag, ".be"}, m_be, b.be);
                    chk({tag, ".we"}, m_we, b.we);
                    if (waited >= ((bidx == 0) ? gnt_lat : 0)) begin
                        gnt = 1'b1; pend = 1'b1; bidx++; waited = 0;
                        void'(beat_q.pop_front());
                    end else waited++;
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) chk({tag, ".unexp_rsp"}, rsp_valid, 0);
                else begin
                    r = rsp_q.pop_front();
                    chk({tag, ".rdata"}, rsp_rdata, r.rdata);
                    chk({tag, ".err"}, rsp_err, r.err);
                    chk({tag, ".lat"}, cyc, r.lat);
                end
                done = 1'b1;
            end
            @(posedge clk);
        end
        if (!done) chk({tag, ".timeout"}, done, 1);
        chk({tag, ".beats_left"}, beat_q.size(), 0);
        beat_q.delete();
        rsp_q.delete();
        @(negedge clk);
        chk({tag, ".pulse"}, rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_type = '0; req_addr = '0;
        req_wdata = '0; gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; rdata = '0; dsel = 0;
        repeat (2) @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            dsel = s; #1;
            chk("rst.ready", req_ready, 1);
            chk("rst.mreq", m_req, 0);
            chk("rst.rsp", rsp_valid, 0);
            chk("rst.rdata", rsp_rdata, 0);
        end
        @(negedge clk); rst = 1'b0;

        exp_beat(32'h100, 0, 0, 0); exp_rsp(64'hFFFF_FF80, 0, 3);
        run("lb", 0, 0, 3'b000, 32'h103, 0, 0, 64'h80FF_FF12, 0, 0);

        exp_beat(32'h100, 64'hCCDD_0000, 8'b1100, 1);
        exp_beat(32'h104, 64'h0000_AABB, 8'b0011, 1); exp_rsp(0, 0, 5);
        run("sw_split", 0, 1, 3'b010, 32'h102, 64'hAABB_CCDD, 0, 0, 0, 0);

        exp_beat(32'h0FC, 0, 0, 0); exp_beat(32'h100, 0, 0, 0); exp_rsp(64'h6655_4433, 0, 5);
        run("lw_split", 0, 0, 3'b010, 32'h0FE, 0, 0, 64'h4433_2211, 64'h8877_6655, 0);

        exp_beat(32'h0FC, 0, 0, 0); exp_beat(32'h100, 0, 0, 0); exp_rsp(64'h6655_4433, 0, 8);
        run("lw_gnt3", 0, 0, 3'b010, 32'h0FE, 0, 3, 64'h4433_2211, 64'h8877_6655, 0);

        exp_beat(32'h0FC, 0, 0, 0); exp_rsp(0, 1, 3);
        run("bus_err", 0, 0, 3'b010, 32'h0FE, 0, 0, 64'h4433_2211, 64'h8877_6655, 1);

        exp_beat(32'h0, 0, 0, 0); exp_beat(32'h4, 0, 0, 0); exp_rsp(64'hFFFF_F811, 0, 5);
        run("lh_split", 0, 0, 3'b001, 32'h3, 0, 0, 64'h1122_3344, 64'h5566_77F8, 0);

        exp_beat(32'h100, 0, 0, 0); exp_rsp(64'h0000_8000, 0, 3);
        run("lhu", 0, 0, 3'b101, 32'h102, 0, 0, 64'h8000_1234, 0, 0);

        exp_beat(32'h100, 64'hFFBE_EF00, 8'b0110, 1); exp_rsp(0, 0, 3);
        run("sh", 0, 1, 3'b001, 32'h101, 64'hFFFF_BEEF, 0, 0, 0, 0);

        exp_beat(32'hFFFF_FFFC, 0, 0, 0); exp_beat(32'h0, 0, 0, 0); exp_rsp(64'h6655_4433, 0, 5);
        run("wrap", 0, 0, 3'b010, 32'hFFFF_FFFE, 0, 0, 64'h4433_2211, 64'h8877_6655, 0);

        exp_rsp(0, 1, 1); run("rsvd111", 0, 0, 3'b111, 32'h100, 0, 0, 0, 0, 0);
        exp_rsp(0, 1, 1); run("sbu_st", 0, 1, 3'b100, 32'h100, 64'h55, 0, 0, 0, 0);
        exp_rsp(0, 1, 1); run("ld_x32", 0, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0);

        // Reset while waiting for rvalid, then a stray rvalid in IDLE must be ignored.
        dsel = 0;
        @(negedge clk); req_valid = 1'b1; req_write = 1'b0; req_type = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0; chk("rstmid.mreq", m_req, 1); gnt = 1'b1;
        @(posedge clk);
        @(negedge clk); gnt = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0; chk("rstmid.ready", req_ready, 1);
        rvalid = 1'b1; rdata = 64'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk); rvalid = 1'b0; rdata = '0;
        for (int k = 0; k < 3; k++) begin
            chk("rstmid.norsp", rsp_valid, 0);
            chk("rstmid.nomreq", m_req, 0);
            @(negedge clk);
        end
        exp_beat(32'h200, 0, 0, 0); exp_rsp(64'h1234_5678, 0, 3);
        run("post_rst", 0, 0, 3'b010, 32'h200, 0, 0, 64'h1234_5678, 0, 0);

        exp_rsp(0, 1, 1); run("nomis_lh", 1, 0, 3'b001, 32'h3, 0, 0, 0, 0, 0);
        exp_rsp(0, 1, 1); run("nomis_ld", 1, 0, 3'b011, 32'h0, 0, 0, 0, 0, 0);
        exp_beat(32'h100, 0, 0, 0); exp_rsp(64'hCAFE_F00D, 0, 3);
        run("nomis_lw", 1, 0, 3'b010, 32'h100, 0, 0, 64'hCAFE_F00D, 0, 0);

        exp_beat(32'h0, 0, 0, 0); exp_beat(32'h8, 0, 0, 0); exp_rsp(64'h0000_0000_BBAA_8877, 0, 5);
        run("x64_lwu", 2, 0, 3'b110, 32'h6, 0, 0, 64'h8877_6655_4433_2211, 64'h0000_BBAA, 0);
        exp_beat(32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 1); exp_rsp(0, 0, 3);
        run("x64_sd", 2, 1, 3'b011, 32'h8, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
        exp_beat(32'h10, 0, 0, 0); exp_rsp(64'hFEDC_BA98_7654_3210, 0, 3);
        run("x64_ld", 2, 0, 3'b011, 32'h10, 0, 0, 64'hFEDC_BA98_7654_3210, 0, 0);
        exp_beat(32'h0, 0, 0, 0); exp_rsp(64'hFFFF_FFFF_8000_0000, 0, 3);
        run("x64_lw", 2, 0, 3'b010, 32'h4, 0, 0, 64'h8000_0000_0000_0000, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
